// File: rtl/corr_pktfifo.sv
// corr_pktfifo: packet-atomic byte FIFO (whole-packet push via i_pkt_*, byte pop/flush via i_pop/i_flush, status o_*)
module corr_pktfifo #(
  parameter int PKT_BYTES = 4,
  parameter int DEPTH = 10
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_cg,
  input  logic [PKT_BYTES*8-1:0]       i_pkt_data,
  input  logic                         i_pkt_valid,
  output logic                         o_pkt_ready,
  output logic                         o_overflow,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic [7:0]                   o_data,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [7:0] mem [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic overflow, doPush, doDrop, doPop, doFlush;
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    return PW'(s >= DEPTH ? s - DEPTH : s);
  endfunction
  always_comb begin
    o_pkt_ready = int'(count) <= DEPTH - PKT_BYTES;
    o_empty = count == '0;
    o_count = count;
    o_overflow = overflow;
    o_data = o_empty ? 8'd0 : mem[rdPtr];
    doFlush = i_cg && i_flush;
    doPush = i_cg && i_pkt_valid && o_pkt_ready && !i_flush;
    doDrop = i_cg && i_pkt_valid && !o_pkt_ready && !i_flush;
    doPop = i_cg && i_pop && !o_empty && !i_flush;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else if (doFlush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrap(wrPtr, PKT_BYTES);
      if (doPop) rdPtr <= wrap(rdPtr, 1);
      if (doDrop) overflow <= 1'b1;
      count <= count + (doPush ? CW'(PKT_BYTES) : '0) - (doPop ? CW'(1) : '0);
    end
  end
  always_ff @(posedge i_clk) begin
    if (doPush)
      for (int k = 0; k < PKT_BYTES; k++) mem[wrap(wrPtr, k)] <= i_pkt_data[k*8 +: 8];
  end
endmodule
